cpu_onchip_mem_arbiter: RTL and testbench

//  Two-master Avalon-MM arbiter sharing one single-port 32-bit on-chip RAM (5120 words,
//  13-bit word address, 4 byte lanes, 1-cycle read latency).

---
 rtl/cpu_onchip_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_cpu_onchip_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter (round-robin, bounded hold) in front of a 1-cycle single-port RAM.
// Optional address range check is compiled in with `define MEMARB_RANGE_CHECK_EN.
module cpu_onchip_mem_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DEPTH    = 5120,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              range_err,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a master holds read/write (and its command fields) stable until it sees
    // waitrequest=0 in the same cycle; that cycle is the accept. Each accepted read gets
    // exactly one readdatavalid pulse on the following cycle; writes have no response.

    if (MAX_HOLD < 1 || MAX_HOLD > 15 || DEPTH < 1) begin : g_param_check
        $error("cpu_onchip_mem_arbiter: MAX_HOLD must be 1..15 and DEPTH >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [3:0]  hold_q, hold_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_own_q, rd_own_d;
    logic        rd_zero_q, rd_zero_d;
    logic        range_err_q, range_err_d;

    logic        req0, req1;
    logic        own, req_own, req_oth;
    logic        gnt_v, gnt_sel;
    logic        sel_write, in_range;
    logic [ADDR_W-1:0] sel_addr;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        gnt_v   = 1'b0;
        gnt_sel = 1'b0;
        hold_d  = 4'd0;
        state_d = IDLE;
        last_d  = last_q;
        own     = (state_q == OWN1);
        req_own = own ? req1 : req0;
        req_oth = own ? req0 : req1;
        if (state_q == OWN0 || state_q == OWN1) begin
            // The owner keeps the RAM until it has used its hold budget while the other waits.
            if (req_own && (!req_oth || hold_q < HOLD_LIM)) begin
                gnt_v   = 1'b1;
                gnt_sel = own;
                hold_d  = (hold_q == 4'hF) ? 4'hF : hold_q + 4'd1;
            end else if (req_oth) begin
                gnt_v   = 1'b1;
                gnt_sel = ~own;
            end
        end else begin
            if (req0 && req1) begin
                gnt_v   = 1'b1;
                gnt_sel = ~last_q;
            end else if (req0 || req1) begin
                gnt_v   = 1'b1;
                gnt_sel = req1;
            end
        end
        if (gnt_v) begin
            state_d = gnt_sel ? OWN1 : OWN0;
            last_d  = gnt_sel;
        end
    end

    assign sel_addr  = gnt_sel ? m1_address : m0_address;
    assign sel_write = gnt_sel ? m1_write : m0_write;

`ifdef MEMARB_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    assign in_range = ({1'b0, sel_addr} < DEPTH_L);
`else
    assign in_range = 1'b1;
`endif

    assign mem_address    = sel_addr;
    assign mem_byteenable = sel_write ? (gnt_sel ? m1_byteenable : m0_byteenable) : 4'hF;
    assign mem_writedata  = gnt_sel ? m1_writedata : m0_writedata;
    assign mem_chipselect = gnt_v & in_range;
    assign mem_write      = gnt_v & sel_write & in_range;
    assign mem_clken      = 1'b1;

    assign m0_waitrequest = req0 & ~(gnt_v & ~gnt_sel);
    assign m1_waitrequest = req1 & ~(gnt_v & gnt_sel);

    assign rd_pend_d   = gnt_v & ~sel_write;
    assign rd_own_d    = gnt_sel;
    assign rd_zero_d   = ~in_range;
    assign range_err_d = range_err_q | (gnt_v & ~in_range);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            hold_q      <= 4'd0;
            rd_pend_q   <= 1'b0;
            rd_own_q    <= 1'b0;
            rd_zero_q   <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            rd_pend_q   <= rd_pend_d;
            rd_own_q    <= rd_own_d;
            rd_zero_q   <= rd_zero_d;
            range_err_q <= range_err_d;
        end
    end

    // Out-of-range reads complete normally but return zero instead of RAM contents.
    assign m0_readdata      = rd_zero_q ? 32'h0 : mem_readdata;
    assign m1_readdata      = rd_zero_q ? 32'h0 : mem_readdata;
    assign m0_readdatavalid = rd_pend_q & ~rd_own_q;
    assign m1_readdatavalid = rd_pend_q & rd_own_q;
    assign range_err        = range_err_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_cpu_onchip_mem_arbiter.sv
// Directed bench for cpu_onchip_mem_arbiter: per-cycle vector table plus hand-written
// sequences for hold rotation, hold saturation and the optional range check.
module tb_cpu_onchip_mem_arbiter;

    localparam logic [1:0] NO = 2'd0, RD = 2'd1, WR = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, mem_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken, range_err;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_onchip_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .range_err(range_err), .dbg_state_o(dbg_state)
    );

    // RAM model: byte-lane writes, one-cycle registered read
    logic [31:0] ram [0:8191];
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    typedef struct {
        logic        rst;
        logic [1:0]  op0;
        logic [12:0] a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic [1:0]  op1;
        logic [12:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic [3:0]  eflags;  // {wait0, wait1, chipselect, write}
        logic [12:0] ea;
        logic [3:0]  ebe;
        logic [1:0]  ev;      // {valid0, valid1}
        logic [31:0] erd;
    } vec_t;

    vec_t        vq[$];
    logic [12:0] exp_q[$];

    function automatic void add(input logic rst,
                                input logic [1:0] op0, input logic [12:0] a0,
                                input logic [3:0] be0, input logic [31:0] d0,
                                input logic [1:0] op1, input logic [12:0] a1,
                                input logic [3:0] be1, input logic [31:0] d1,
                                input logic [3:0] ef, input logic [12:0] ea,
                                input logic [3:0] ebe, input logic [1:0] ev,
                                input logic [31:0] erd);
        vec_t v;
        v.rst = rst; v.op0 = op0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
        v.op1 = op1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.eflags = ef; v.ea = ea; v.ebe = ebe; v.ev = ev; v.erd = erd;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst,
                         input logic [1:0] op0, input logic [12:0] a0,
                         input logic [3:0] be0, input logic [31:0] d0,
                         input logic [1:0] op1, input logic [12:0] a1,
                         input logic [3:0] be1, input logic [31:0] d1);
        reset = rst;
        m0_read = (op0 == RD); m0_write = (op0 == WR);
        m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
        m1_read = (op1 == RD); m1_write = (op1 == WR);
        m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rst);
        drive(rst, NO, 13'h0, 4'h0, 32'h0, NO, 13'h0, 4'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 8192; i++) ram[i] <= 32'h0;
        ram[13'h0010] <= 32'hCAFE0001;
        ram[13'h0001] <= 32'h11111111;
        ram[13'h0002] <= 32'h22222222;
        ram[13'h0003] <= 32'h33333333;
        ram[13'h1400] <= 32'h51200000;
        idle(1'b1);

        // reset
        add(1, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b00, 0);
        add(1, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b00, 0);
        // single m0 read
        add(0, RD,13'h010,0,0,        NO,0,0,0,              4'b0010, 13'h010,4'hF, 2'b00, 0);
        add(0, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b10, 32'hCAFE0001);
        add(0, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b00, 0);
        // writes from reset, first tie to m0, then alternation
        add(1, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b00, 0);
        add(0, WR,13'h020,4'hF,32'hA0A0A0A0, WR,13'h021,4'hF,32'hB1B1B1B1, 4'b0111, 13'h020,4'hF, 2'b00, 0);
        add(0, NO,0,0,0,              WR,13'h021,4'hF,32'hB1B1B1B1, 4'b0011, 13'h021,4'hF, 2'b00, 0);
        add(0, WR,13'h022,4'h3,32'hA2A2A2A2, NO,0,0,0,       4'b0011, 13'h022,4'h3, 2'b00, 0);
        add(0, NO,0,0,0,              WR,13'h023,4'hF,32'hB3B3B3B3, 4'b0011, 13'h023,4'hF, 2'b00, 0);
        // m0 stream, m1 joins in cycle 2, granted after the 4th m0 grant
        add(0, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b00, 0);
        add(0, RD,13'h001,0,0,        NO,0,0,0,              4'b0010, 13'h001,4'hF, 2'b00, 0);
        add(0, RD,13'h002,0,0,        NO,0,0,0,              4'b0010, 13'h002,4'hF, 2'b10, 32'h11111111);
        add(0, RD,13'h003,0,0,        RD,13'h010,0,0,        4'b0110, 13'h003,4'hF, 2'b10, 32'h22222222);
        add(0, RD,13'h022,0,0,        RD,13'h010,0,0,        4'b0110, 13'h022,4'hF, 2'b10, 32'h33333333);
        add(0, RD,13'h020,0,0,        RD,13'h010,0,0,        4'b1010, 13'h010,4'hF, 2'b10, 32'h0000A2A2);
        add(0, RD,13'h020,0,0,        NO,0,0,0,              4'b0010, 13'h020,4'hF, 2'b01, 32'hCAFE0001);
        add(0, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b10, 32'hA0A0A0A0);
        add(0, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b00, 0);
        // alternating back-to-back reads
        add(0, RD,13'h001,0,0,        NO,0,0,0,              4'b0010, 13'h001,4'hF, 2'b00, 0);
        add(0, NO,0,0,0,              RD,13'h002,0,0,        4'b0010, 13'h002,4'hF, 2'b10, 32'h11111111);
        add(0, RD,13'h003,0,0,        NO,0,0,0,              4'b0010, 13'h003,4'hF, 2'b01, 32'h22222222);
        add(0, NO,0,0,0,              RD,13'h021,0,0,        4'b0010, 13'h021,4'hF, 2'b10, 32'h33333333);
        add(0, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b01, 32'hB1B1B1B1);
        add(0, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b00, 0);
        // read accepted during reset is dropped; next tie goes to m0
        add(1, RD,13'h010,0,0,        NO,0,0,0,              4'b0010, 13'h010,4'hF, 2'b00, 0);
        add(0, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b00, 0);
        add(0, RD,13'h003,0,0,        RD,13'h002,0,0,        4'b0110, 13'h003,4'hF, 2'b00, 0);
        add(0, NO,0,0,0,              RD,13'h002,0,0,        4'b0010, 13'h002,4'hF, 2'b10, 32'h33333333);
        add(0, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b01, 32'h22222222);
        add(0, NO,0,0,0,              NO,0,0,0,              4'b0000, 0,0,    2'b00, 0);

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            drive(v.rst, v.op0, v.a0, v.be0, v.d0, v.op1, v.a1, v.be1, v.d1);
            @(negedge clk);
            chk($sformatf("v%0d wait0", i), 32'(m0_waitrequest), 32'(v.eflags[3]));
            chk($sformatf("v%0d wait1", i), 32'(m1_waitrequest), 32'(v.eflags[2]));
            chk($sformatf("v%0d cs", i),    32'(mem_chipselect), 32'(v.eflags[1]));
            chk($sformatf("v%0d we", i),    32'(mem_write),      32'(v.eflags[0]));
            if (v.eflags[1]) begin
                chk($sformatf("v%0d addr", i), 32'(mem_address),    32'(v.ea));
                chk($sformatf("v%0d be", i),   32'(mem_byteenable), 32'(v.ebe));
            end
            chk($sformatf("v%0d rvalid0", i), 32'(m0_readdatavalid), 32'(v.ev[1]));
            chk($sformatf("v%0d rvalid1", i), 32'(m1_readdatavalid), 32'(v.ev[0]));
            if (v.ev[1]) chk($sformatf("v%0d rdata0", i), m0_readdata, v.erd);
            if (v.ev[0]) chk($sformatf("v%0d rdata1", i), m1_readdata, v.erd);
            chk($sformatf("v%0d range_err", i), 32'(range_err), 32'h0);
            step();
        end

        // both masters stream writes from reset: blocks of MAX_HOLD=4 grants each
        idle(1'b1);
        step();
        for (int k = 0; k < 12; k++) exp_q.push_back(((k / 4) % 2 == 1) ? 13'h031 : 13'h030);
        for (int k = 0; k < 12; k++) begin
            logic [12:0] e;
            drive(0, WR, 13'h030, 4'hF, 32'(k), WR, 13'h031, 4'hF, 32'(k));
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("rot%0d addr", k), 32'(mem_address), 32'(e));
            chk($sformatf("rot%0d wait", k), 32'({m0_waitrequest, m1_waitrequest}),
                (e == 13'h030) ? 32'h1 : 32'h2);
            step();
        end
        idle(1'b0);
        step();

        // hold counter saturates during a long solo stream; m1 then wins at once
        for (int k = 0; k < 18; k++) begin
            drive(0, RD, 13'(k), 4'h0, 32'h0, NO, 13'h0, 4'h0, 32'h0);
            step();
        end
        drive(0, RD, 13'h005, 4'h0, 32'h0, RD, 13'h006, 4'h0, 32'h0);
        @(negedge clk);
        chk("sat wait", 32'({m0_waitrequest, m1_waitrequest}), 32'h2);
        chk("sat addr", 32'(mem_address), 32'h006);
        step();
        idle(1'b0);
        step();
        step();

`ifdef MEMARB_RANGE_CHECK_EN
        idle(1'b1);
        step();
        drive(0, NO, 13'h0, 4'h0, 32'h0, WR, 13'h1400, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        chk("oor wr cs", 32'(mem_chipselect), 32'h0);
        chk("oor wr wait1", 32'(m1_waitrequest), 32'h0);
        chk("oor wr range_err", 32'(range_err), 32'h0);
        step();
        drive(0, NO, 13'h0, 4'h0, 32'h0, RD, 13'h1400, 4'h0, 32'h0);
        @(negedge clk);
        chk("oor rd cs", 32'(mem_chipselect), 32'h0);
        chk("oor rd wait1", 32'(m1_waitrequest), 32'h0);
        chk("oor rd range_err", 32'(range_err), 32'h1);
        step();
        idle(1'b0);
        @(negedge clk);
        chk("oor rvalid1", 32'(m1_readdatavalid), 32'h1);
        chk("oor rdata1", m1_readdata, 32'h0);
        chk("oor sticky", 32'(range_err), 32'h1);
        step();
        idle(1'b1);
        step();
        idle(1'b0);
        @(negedge clk);
        chk("oor cleared", 32'(range_err), 32'h0);
        step();
`else
        drive(0, NO, 13'h0, 4'h0, 32'h0, RD, 13'h1400, 4'h0, 32'h0);
        @(negedge clk);
        chk("hi rd cs", 32'(mem_chipselect), 32'h1);
        chk("hi rd addr", 32'(mem_address), 32'h1400);
        step();
        idle(1'b0);
        @(negedge clk);
        chk("hi rvalid1", 32'(m1_readdatavalid), 32'h1);
        chk("hi rdata1", m1_readdata, 32'h51200000);
        chk("hi range_err", 32'(range_err), 32'h0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
